// File: rtl/ifu_fetch_pkg.sv
// Shared constants, redirect encodings and the PC legality rule for the
// instruction fetch unit.
package ifu_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_DEPTH = 256;
  localparam int          IM_AW    = 8;

  // First address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = RESET_PC + 32'(4 * IM_DEPTH);

  typedef enum logic [1:0] {
    SEL_BRANCH = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_JR     = 2'd2,
    SEL_RSVD   = 2'd3
  } redirect_sel_e;

  localparam int IMM16_MSB = 15;
  localparam int IMM26_MSB = 25;

  function automatic logic pc_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= RESET_PC) && (addr < PC_LIMIT);
  endfunction

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Next-PC arithmetic: sequential successor and decode-requested redirect
// target, each with a flag saying whether it may be loaded into the PC.
module ifu_fetch_npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc,
  input  logic [1:0]  redirect_sel,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] seq_pc,
  output logic        seq_legal,
  output logic [31:0] redir_pc,
  output logic        redir_legal
);

  logic [31:0] link_pc;
  logic [31:0] branch_off;
  logic        sel_ok;

  assign seq_pc     = pc + 32'd4;
  assign seq_legal  = pc_legal(seq_pc);
  assign link_pc    = if_id_pc + 32'd4;
  assign branch_off = {{14{redirect_imm[IMM16_MSB]}}, redirect_imm[IMM16_MSB:0], 2'b00};

  // Targets are relative to the instruction sitting in IF/ID, not the fetch PC.
  always_comb begin
    redir_pc = link_pc + branch_off;
    sel_ok   = 1'b1;
    case (redirect_sel_e'(redirect_sel))
      SEL_BRANCH: redir_pc = link_pc + branch_off;
      SEL_JUMP:   redir_pc = {link_pc[31:28], redirect_imm[IMM26_MSB:0], 2'b00};
      SEL_JR:     redir_pc = jr_target;
      SEL_RSVD: begin
        redir_pc = pc;
        sel_ok   = 1'b0;
      end
      default: ;
    endcase
  end

  assign redir_legal = sel_ok && pc_legal(redir_pc);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, addresses instruction memory and
// fills the IF/ID register, honouring redirects, stalls and fetch faults.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_sel,
  input  logic [25:0]      redirect_imm,
  input  logic [31:0]      jr_target,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic             if_id_valid,
  output logic             fault
);

  localparam logic [IM_AW-1:0] BASE_WORD = RESET_PC[IM_AW+1:2];

  logic [31:0] seq_pc;
  logic [31:0] redir_pc;
  logic        seq_legal;
  logic        redir_legal;
  logic        redirect_taken;

  ifu_fetch_npc_calc u_npc_calc (
    .pc           (pc),
    .if_id_pc     (if_id_pc),
    .redirect_sel (redirect_sel),
    .redirect_imm (redirect_imm),
    .jr_target    (jr_target),
    .seq_pc       (seq_pc),
    .seq_legal    (seq_legal),
    .redir_pc     (redir_pc),
    .redir_legal  (redir_legal)
  );

  // Low-bit subtraction equals the low bits of the full pc - RESET_PC.
  assign im_addr        = pc[IM_AW+1:2] - BASE_WORD;
  assign redirect_taken = redirect_valid && if_id_valid;

  // Priority: reset, terminal fault, redirect (even under stall), stall, fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (fault) begin
      if_id_valid <= 1'b0;
    end else if (redirect_taken) begin
      if_id_valid <= 1'b0;
      if (redir_legal) begin
        pc <= redir_pc;
      end else begin
        fault <= 1'b1;
      end
    end else if (!stall) begin
      if (seq_legal) begin
        if_id_instr <= im_data;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
        pc          <= seq_pc;
      end else begin
        fault       <= 1'b1;
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; sits directly upstream of the 256-word instruction memory.
- Owns the PC and drives the word address into the memory; the memory returns data combinationally.
- Latches the fetched word plus its PC into the IF/ID register for decode.
- Computes redirect targets for branch, j/jal and jr requests issued by decode, squashing the wrong-path fetch; no delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; also base address of instruction memory.
- IM_DEPTH, 256, instruction memory depth in words.
- IM_AW, 8, instruction memory word-address width; log2(IM_DEPTH).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode not ready; hold PC and IF/ID.
- redirect_valid  in  1  decode requests control transfer for the instruction in IF/ID.
- redirect_sel  in  2  0=branch, 1=jump, 2=jr, 3=reserved.
- redirect_imm  in  26  instr[25:0]; branch uses [15:0].
- jr_target  in  32  register value for jr.
- im_addr  out  IM_AW  word address to instruction memory, = (pc - RESET_PC)[IM_AW+1:2].
- im_data  in  32  instruction word from memory, valid same cycle.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a live instruction.
- fault  out  1  sticky fetch fault; misaligned or out-of-range PC.

Behaviour:
- Reset values:
  - pc=RESET_PC, im_addr=0.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0, fault=0.
- Reset dominates all other inputs on any cycle, including mid-stall and mid-redirect.
- Fetch latency is 1 cycle: the word addressed by pc in cycle N appears on if_id_instr in cycle N+1.
- Priority per cycle, evaluated in this order:
  - rst.
  - fault.
  - accepted redirect.
  - stall.
  - sequential.
- Accepted redirect:
  - Condition: redirect_valid=1 and if_id_valid=1.
  - A redirect with if_id_valid=0 is ignored.
- Target rules, all 32-bit with wrap-around, no overflow detection:
  - branch (sel 0): if_id_pc + 4 + (sign_extend(imm[15:0]) << 2).
  - jump (sel 1): {(if_id_pc + 4)[31:28], imm[25:0], 2'b00}.
  - jr (sel 2): jr_target.
  - sel 3: fault.
- Redirect action:
  - Taken even when stall=1.
  - pc <= target; if_id_valid <= 0 to squash the wrong-path word.
  - if_id_instr and if_id_pc hold.
- Stall with no accepted redirect: pc, if_id_instr, if_id_pc and if_id_valid all hold.
- Sequential fetch:
  - if_id_instr <= im_data; if_id_pc <= pc; if_id_valid <= 1; pc <= pc + 4.
- Range/alignment check, applied to every value about to be loaded into pc:
  - pc[1:0] != 0, or pc < RESET_PC, or pc >= RESET_PC + 4*IM_DEPTH → fault instead of load.
  - On fault: fault <= 1; pc holds its last legal value; if_id_valid <= 0.
  - Sequential step from the last word (RESET_PC + 4*(IM_DEPTH-1)) → fault; no wrap to word 0.
- Fault state:
  - Fault is terminal until rst.
  - In fault: no fetch, redirects and stall ignored, if_id_valid stays 0.
- im_addr is derived combinationally from the pc register, never from next-PC, so the memory sees a stable address all cycle.

Decomposition:
- Shared package holds:
  - RESET_PC and IM_DEPTH constants.
  - Redirect-select encodings: SEL_BRANCH=2'd0, SEL_JUMP=2'd1, SEL_JR=2'd2.
  - Instruction field slice positions: imm16 [15:0], imm26 [25:0].
- One sub-module is natural: npc_calc, purely combinational.
  - Inputs: pc, if_id_pc, redirect_sel, redirect_imm, jr_target.
  - Outputs: seq/redirect target and the legality flag.
- The top holds the PC, IF/ID and fault registers plus the priority logic.

Test Plan:
- Reset then 3 free-running cycles with im_data = 0x20080001, 0x20090002, 0x01095020 → pc 0x3000→0x300C; im_addr 0,1,2; if_id_pc 0x3000,0x3004,0x3008; if_id_valid=1 from cycle 1.
- stall=1 for 2 cycles at pc=0x3008 → pc, if_id_instr and if_id_valid frozen; resume with pc=0x300C on release.
- Branch: if_id_pc=0x3004, imm16=0xFFFF, sel 0 → pc=0x3004; next cycle if_id_valid=0; following cycle fetches 0x3004.
- Jump with stall=1: if_id_pc=0x3010, imm26=0x0000C05 → pc=0x3014, squash despite stall; jr with jr_target=0x3020 → pc=0x3020.
- Faults, each from a fresh reset:
  - jr_target=0x3022 (misaligned) → fault=1, pc unchanged.
  - jr_target=0x4000 (out of range) → fault=1, pc unchanged.
  - sel 3 → fault=1, pc unchanged.
  - Sequential run to pc=0x33FC → one more step faults, pc stays 0x33FC.
  - In every case, subsequent redirects are ignored until rst.
- rst asserted mid-redirect with stall=1 → all outputs return to reset values on that edge.
